// File: rtl/prefix_subtractor_pipe.sv
// Kogge-Stone prefix subtractor computing A - B - BI on a valid/ready stream.
// Latency: LVLS+2 cycles from input handshake to o_VALID (8 for WIDTH=64); 1 op/cycle.
// Backpressure: per-stage valids collapse bubbles; o_READY is combinational from i_READY.
module prefix_subtractor_pipe #(
    parameter int WIDTH = 64
) (
    input  logic             i_CLK,
    input  logic             i_RST,
    input  logic             i_VALID,
    output logic             o_READY,
    input  logic [WIDTH-1:0] i_A,
    input  logic [WIDTH-1:0] i_B,
    input  logic             i_BI,
    output logic             o_VALID,
    input  logic             i_READY,
    output logic [WIDTH-1:0] o_DIFF,
    output logic             o_BO,
    output logic             o_OVF,
    output logic             o_ZERO
);

    localparam int LVLS = $clog2(WIDTH);
    // Index of the output stage; stages 0..LVLS carry prefix state.
    localparam int LAST = LVLS + 1;

    // Prefix state carried between stages. pg is the group propagate that the
    // prefix levels reduce; p keeps the per-bit propagate for the final XOR.
    typedef struct packed {
        logic [WIDTH-1:0] g;
        logic [WIDTH-1:0] pg;
        logic [WIDTH-1:0] p;
        logic             c0;
        logic             a_msb;
        logic             b_msb;
    } stage_t;

    stage_t           st_q   [0:LVLS];
    stage_t           st_d   [0:LVLS];
    stage_t           src;
    int               span;

    logic             vld    [0:LAST];
    logic             adv    [0:LAST];
    logic             load_ok[0:LAST];
    logic             in_fire;

    logic [WIDTH-1:0] diff_d;
    logic             bo_d;
    logic             ovf_d;
    logic             zero_d;

    // Stall chain: a stage advances when valid and the next stage can take it;
    // it can load when empty or when its own content advances this cycle.
    always_comb begin
        for (int i = 0; i <= LAST; i++) begin
            adv[i]     = 1'b0;
            load_ok[i] = 1'b0;
        end
        adv[LAST]     = vld[LAST] & i_READY;
        load_ok[LAST] = ~vld[LAST] | i_READY;
        for (int i = LAST - 1; i >= 0; i--) begin
            adv[i]     = vld[i] & load_ok[i + 1];
            load_ok[i] = ~vld[i] | adv[i];
        end
    end

    assign o_READY = load_ok[0];
    assign in_fire = i_VALID & load_ok[0] & ~i_RST;

    // Generate/propagate formation for A + ~B + ~BI, and the prefix levels.
    always_comb begin
        st_d[0].g     = i_A & ~i_B;
        st_d[0].pg    = i_A ^ ~i_B;
        st_d[0].p     = i_A ^ ~i_B;
        st_d[0].c0    = ~i_BI;
        st_d[0].a_msb = i_A[WIDTH-1];
        st_d[0].b_msb = i_B[WIDTH-1];
        src  = st_q[0];
        span = 1;
        for (int k = 1; k <= LVLS; k++) begin
            src  = st_q[k-1];
            span = 1 << (k - 1);
            // Fold the carry-in into bit 0 so every group generate is a true carry.
            if (k == 1) begin
                src.g[0] = src.g[0] | (src.pg[0] & src.c0);
            end
            st_d[k] = src;
            for (int i = 0; i < WIDTH; i++) begin
                if (i >= span) begin
                    st_d[k].g[i]  = src.g[i] | (src.pg[i] & src.g[i - span]);
                    st_d[k].pg[i] = src.pg[i] & src.pg[i - span];
                end
            end
        end
    end

    // Sum formation and flags from the fully reduced carries.
    always_comb begin
        diff_d = st_q[LVLS].p ^ {st_q[LVLS].g[WIDTH-2:0], st_q[LVLS].c0};
        bo_d   = ~st_q[LVLS].g[WIDTH-1];
        ovf_d  = (st_q[LVLS].a_msb != st_q[LVLS].b_msb) &&
                 (diff_d[WIDTH-1] != st_q[LVLS].a_msb);
        zero_d = (diff_d == '0);
    end

    // Stage valid bits: a stage that can load takes the valid of its upstream.
    always_ff @(posedge i_CLK) begin
        if (i_RST) begin
            for (int i = 0; i <= LAST; i++) begin
                vld[i] <= 1'b0;
            end
        end else begin
            if (load_ok[0]) begin
                vld[0] <= i_VALID;
            end
            for (int i = 1; i <= LAST; i++) begin
                if (load_ok[i]) begin
                    vld[i] <= adv[i-1];
                end
            end
        end
    end

    // Prefix payload registers: no reset, they only load on a stage advance.
    always_ff @(posedge i_CLK) begin
        if (in_fire) begin
            st_q[0] <= st_d[0];
        end
        for (int k = 1; k <= LVLS; k++) begin
            if (adv[k-1]) begin
                st_q[k] <= st_d[k];
            end
        end
    end

    // Output stage: reset to zero, holds while the consumer stalls.
    always_ff @(posedge i_CLK) begin
        if (i_RST) begin
            o_DIFF <= '0;
            o_BO   <= 1'b0;
            o_OVF  <= 1'b0;
            o_ZERO <= 1'b0;
        end else if (adv[LVLS]) begin
            o_DIFF <= diff_d;
            o_BO   <= bo_d;
            o_OVF  <= ovf_d;
            o_ZERO <= zero_d;
        end
    end

    assign o_VALID = vld[LAST];

    // Group propagate is not needed past the last prefix level.
    logic unused_pg;
    assign unused_pg = &{1'b0, st_q[LVLS].pg};

endmodule

// File: tb/tb_prefix_subtractor_pipe.sv
// Scoreboard bench for prefix_subtractor_pipe: directed vectors, stall stream,
// mid-stream reset and a random stream with random valid/ready.
module tb_prefix_subtractor_pipe;
    localparam int W   = 64;
    localparam int LAT = 8;

    logic         i_CLK = 1'b0;
    logic         i_RST;
    logic         i_VALID;
    logic         o_READY;
    logic [W-1:0] i_A;
    logic [W-1:0] i_B;
    logic         i_BI;
    logic         o_VALID;
    logic         i_READY;
    logic [W-1:0] o_DIFF;
    logic         o_BO;
    logic         o_OVF;
    logic         o_ZERO;

    prefix_subtractor_pipe #(.WIDTH(W)) dut (
        .i_CLK   (i_CLK),
        .i_RST   (i_RST),
        .i_VALID (i_VALID),
        .o_READY (o_READY),
        .i_A     (i_A),
        .i_B     (i_B),
        .i_BI    (i_BI),
        .o_VALID (o_VALID),
        .i_READY (i_READY),
        .o_DIFF  (o_DIFF),
        .o_BO    (o_BO),
        .o_OVF   (o_OVF),
        .o_ZERO  (o_ZERO)
    );

    always #5 i_CLK = ~i_CLK;

    typedef struct {
        logic [W-1:0] diff;
        logic         bo;
        logic         ovf;
        logic         zero;
        int           acc;
        bit           lat;
    } exp_t;

    exp_t q[$];
    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    int   ready_mode = 0;
    int   stall_base = 0;
    int   full_seen = 0;

    always @(posedge i_CLK) cyc <= cyc + 1;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    function automatic exp_t mk(input logic [W-1:0] d, input logic bo, input logic ovf,
                                input logic zero, input bit lat);
        exp_t e;
        e.diff = d; e.bo = bo; e.ovf = ovf; e.zero = zero; e.acc = 0; e.lat = lat;
        return e;
    endfunction

    function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b, input logic bi);
        logic [W:0] full;
        logic [W-1:0] d;
        full = {1'b0, a} - {1'b0, b} - {{W{1'b0}}, bi};
        d    = full[W-1:0];
        return mk(d, full[W], (a[W-1] != b[W-1]) && (d[W-1] != a[W-1]), d == '0, 1'b0);
    endfunction

    // Consumer ready pattern, updated on every falling edge.
    initial begin
        i_READY = 1'b1;
        forever begin
            @(negedge i_CLK);
            case (ready_mode)
                0: i_READY = 1'b1;
                1: i_READY = ($urandom % 4) != 0;
                2: i_READY = !((cyc - stall_base) >= 10 && (cyc - stall_base) <= 14);
                default: i_READY = 1'b0;
            endcase
        end
    end

    // Issue one op; holds it until accepted. Entered and left on a falling edge.
    task automatic send(input logic [W-1:0] a, input logic [W-1:0] b, input logic bi, input exp_t e);
        int  n;
        bit  done;
        n = 0; done = 0;
        i_VALID = 1'b1; i_A = a; i_B = b; i_BI = bi;
        while (!done) begin
            #1;
            if (q.size() == LAT && !i_READY) begin
                full_seen++;
                check("ready_low_when_full", {127'b0, o_READY}, 128'd0);
            end
            if (o_READY) begin
                e.acc = cyc;
                q.push_back(e);
                done = 1;
            end
            @(negedge i_CLK);
            n++;
            if (!done && n > 1000) begin
                check("accept_timeout", 128'd0, 128'd1);
                done = 1;
            end
        end
        i_VALID = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (q.size() != 0 && n < 300) begin
            @(negedge i_CLK);
            n++;
        end
        if (q.size() != 0) check("drain_timeout", 128'(q.size()), 128'd0);
        repeat (12) @(negedge i_CLK);
    endtask

    // Monitor: pops the scoreboard on each output handshake and checks hold under stall.
    initial begin
        exp_t         e;
        logic [W+2:0] prev;
        bit           prev_stall;
        prev_stall = 0;
        prev = '0;
        forever begin
            @(negedge i_CLK);
            #2;
            if (!i_RST) begin
                if (prev_stall)
                    check("stall_hold", 128'({o_DIFF, o_BO, o_OVF, o_ZERO}), 128'(prev));
                if (o_VALID && i_READY) begin
                    if (q.size() == 0) begin
                        check("unexpected_output", 128'({o_DIFF, o_BO}), 128'd0);
                    end else begin
                        e = q.pop_front();
                        check("result", 128'({o_BO, o_OVF, o_ZERO, o_DIFF}),
                              128'({e.bo, e.ovf, e.zero, e.diff}));
                        if (e.lat) check("latency", 128'(cyc - e.acc), 128'(LAT));
                    end
                end
            end
            prev_stall = o_VALID && !i_READY && !i_RST;
            prev = {o_DIFF, o_BO, o_OVF, o_ZERO};
        end
    end

    initial begin
        exp_t         e;
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic         bi;

        i_RST = 1'b1; i_VALID = 1'b0; i_A = '0; i_B = '0; i_BI = 1'b0;
        repeat (3) @(negedge i_CLK);
        i_RST = 1'b0;
        #1;
        check("reset_state", 128'({o_VALID, o_READY, o_BO, o_OVF, o_ZERO, o_DIFF}),
              128'({1'b0, 1'b1, 1'b0, 1'b0, 1'b0, {W{1'b0}}}));
        @(negedge i_CLK);

        // 1: basic difference with latency
        send(64'd5, 64'd3, 1'b0, mk(64'd2, 1'b0, 1'b0, 1'b0, 1'b1));
        drain();

        // 2: borrow out and zero result
        send(64'd0, 64'd1, 1'b0, mk(64'hFFFF_FFFF_FFFF_FFFF, 1'b1, 1'b0, 1'b0, 1'b0));
        send(64'd7, 64'd6, 1'b1, mk(64'd0, 1'b0, 1'b0, 1'b1, 1'b0));
        // 3: signed overflow at the most negative value
        send(64'h8000_0000_0000_0000, 64'd1, 1'b0,
             mk(64'h7FFF_FFFF_FFFF_FFFF, 1'b0, 1'b1, 1'b0, 1'b0));
        // positive minus negative overflowing into the sign bit
        send(64'h7FFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0,
             mk(64'h8000_0000_0000_0000, 1'b1, 1'b1, 1'b0, 1'b0));
        // borrow-in ripples across the full width
        send(64'd0, 64'd0, 1'b1, mk(64'hFFFF_FFFF_FFFF_FFFF, 1'b1, 1'b0, 1'b0, 1'b0));
        drain();

        // 4: back-to-back stream with a consumer stall
        full_seen = 0;
        stall_base = cyc;
        ready_mode = 2;
        for (int i = 0; i < 20; i++) begin
            a = 64'(i) * 64'h0123_4567_89AB + 64'd17;
            b = 64'(i * i) * 64'h0F0F_0F0F + 64'd3;
            bi = 1'(i & 1);
            send(a, b, bi, model(a, b, bi));
        end
        drain();
        ready_mode = 0;
        check("stall_filled_pipe", 128'(full_seen > 0), 128'd1);

        // 5: reset with ops in flight
        ready_mode = 3;
        @(negedge i_CLK);
        for (int i = 0; i < 5; i++) send(64'(100 + i), 64'd1, 1'b0, model(64'(100 + i), 64'd1, 1'b0));
        i_RST = 1'b1;
        i_VALID = 1'b1; i_A = 64'd55; i_B = 64'd11; i_BI = 1'b0;
        q.delete();
        @(negedge i_CLK);
        i_RST = 1'b0;
        i_VALID = 1'b0;
        #1;
        check("reset_flush", 128'({o_VALID, o_READY, o_BO, o_OVF, o_ZERO, o_DIFF}),
              128'({1'b0, 1'b1, 1'b0, 1'b0, 1'b0, {W{1'b0}}}));
        ready_mode = 0;
        @(negedge i_CLK);
        send(64'd9, 64'd4, 1'b0, mk(64'd5, 1'b0, 1'b0, 1'b0, 1'b1));
        drain();

        // 6: random stream with random valid/ready
        ready_mode = 1;
        for (int i = 0; i < 10000; i++) begin
            if (($urandom % 4) == 0) @(negedge i_CLK);
            a  = {$urandom, $urandom};
            b  = (($urandom % 16) == 0) ? a : {$urandom, $urandom};
            bi = 1'($urandom % 2);
            send(a, b, bi, model(a, b, bi));
        end
        ready_mode = 0;
        drain();
        check("scoreboard_empty", 128'(q.size()), 128'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
